// File: rtl/sync_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_event_arbiter_pkg
// Description : Shared FSM state encoding and index-width helper for the
//               sync_event_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_event_arbiter_pkg;

   // Scheduler states: nothing offered / one event offered downstream
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   // Width of a requester index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : sync_event_arbiter_pkg
`default_nettype wire

// File: rtl/sync_event_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Scans the request vector
//               upward from a start index, wrapping at N_REQ-1 -> 0, and
//               reports the first set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  start,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   localparam logic [ID_W:0] C_N_WIDE = (ID_W + 1)'(N_REQ);

   logic [ID_W:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit is kept
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, start} + (ID_W + 1)'(k);
         if (cand >= C_N_WIDE) begin
            cand = cand - C_N_WIDE;
         end
         if (req[cand[ID_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[ID_W-1:0];
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sync_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sync_event_arbiter
// Description : Captures one-cycle edge pulses from N_REQ synchronizers into
//               pending bits, grants them round-robin onto a single
//               valid/ready channel and counts events lost to an already
//               pending request (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_event_arbiter
   import sync_event_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_width(N_REQ),
   parameter int CNT_W = 8
) (
   input  logic             clk_fast,
   input  logic             rst,
   input  logic [N_REQ-1:0] evt_in,
   input  logic             enable,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_id,
   input  logic             out_ready,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             busy
);

   localparam logic [ID_W:0]      C_N_WIDE  = (ID_W + 1)'(N_REQ);
   localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;
   localparam logic [N_REQ-1:0]   C_ONE     = N_REQ'(1);

   // Registered state
   logic [0:0]       state_q,     state_d;
   logic [N_REQ-1:0] pending_q,   pending_d;
   logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [ID_W-1:0]  out_id_q,    out_id_d;
   logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

   // Combinational helpers
   logic              handshake;
   logic [N_REQ-1:0]  out_id_onehot;
   logic [N_REQ-1:0]  clr;
   logic [N_REQ-1:0]  drop_vec;
   logic [ID_W:0]     drop_num;
   logic [CNT_W+ID_W:0] cnt_sum;
   logic [ID_W:0]     id_inc;
   logic [ID_W-1:0]   rr_ptr_next;
   logic [N_REQ-1:0]  pick_req;
   logic [ID_W-1:0]   pick_start;
   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;

   assign handshake     = out_valid_q & out_ready;
   assign out_id_onehot = C_ONE << out_id_q;
   assign clr           = handshake ? out_id_onehot : '0;

   // Pointer position just past the currently offered requester
   assign id_inc      = {1'b0, out_id_q} + (ID_W + 1)'(1);
   assign rr_ptr_next = (id_inc == C_N_WIDE) ? '0 : id_inc[ID_W-1:0];

   // A new pulse always lands in pending; it only counts as lost when the
   // bit was already set and is not being consumed in this same cycle
   always_comb begin
      pending_d = evt_in | (pending_q & ~clr);
      drop_vec  = evt_in & pending_q & ~clr;
      drop_num  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         drop_num = drop_num + (ID_W + 1)'(drop_vec[i]);
      end
      cnt_sum = {{(ID_W + 1){1'b0}}, drop_cnt_q} + {{CNT_W{1'b0}}, drop_num};
      if (cnt_sum > {{(ID_W + 1){1'b0}}, C_CNT_MAX}) begin
         drop_cnt_d = C_CNT_MAX;
      end else begin
         drop_cnt_d = cnt_sum[CNT_W-1:0];
      end
   end

   // In OFFER the next pick skips the requester being consumed and starts
   // from the post-handshake pointer; same-cycle pulses are not visible
   always_comb begin
      pick_req   = pending_q;
      pick_start = rr_ptr_q;
      if (state_q == ST_OFFER) begin
         pick_req   = pending_q & ~out_id_onehot;
         pick_start = rr_ptr_next;
      end
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req   (pick_req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Offer FSM: an offer is only withdrawn by a handshake (or reset)
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && pick_found) begin
               state_d     = ST_OFFER;
               out_valid_d = 1'b1;
               out_id_d    = pick_idx;
            end
         end
         ST_OFFER: begin
            if (handshake) begin
               rr_ptr_d = rr_ptr_next;
               if (enable && pick_found) begin
                  out_id_d = pick_idx;
               end else begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
               end
            end
         end
      endcase
   end

   // State registers with synchronous reset; pulses in a reset cycle are lost
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign drop_cnt  = drop_cnt_q;
   assign busy      = (|pending_q) | out_valid_q;

endmodule : sync_event_arbiter
`default_nettype wire

// File: doc/sync_event_arbiter.md
# sync_event_arbiter

Fast-domain scheduler that shares one downstream event channel between `N_REQ` single-bit edge-detect synchronizers. It captures each requester's one-cycle `clk_fast` edge pulse into a pending bit and grants pending requesters round-robin. It presents one event at a time on a valid/ready channel and counts events lost because that requester already had an event pending. It sits immediately after the bank of slow-to-fast edge-detect synchronizers.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be ≥ 2.
- `ID_W`, `$clog2(N_REQ)`: width of the requester index.
- `CNT_W`, 8: width of the drop counter.

Ports:
- `clk_fast`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `evt_in`  in  `N_REQ`: one-cycle edge pulses from the synchronizers; bit i belongs to requester i.
- `enable`  in  1: when low, no new grant is issued; event capture continues.
- `out_valid`  out  1: an event is offered.
- `out_id`  out  `ID_W`: index of the offered requester.
- `out_ready`  in  1: consumer accepts; a handshake is `out_valid & out_ready` at a rising edge.
- `drop_cnt`  out  `CNT_W`: saturating count of dropped events.
- `busy`  out  1: high when any pending bit is set or `out_valid` is high.

## Operation
- Reset values: `pending`=0, `rr_ptr`=0, state IDLE, `out_valid`=0, `out_id`=0, `drop_cnt`=0, `busy`=0. `evt_in` sampled in a reset cycle is discarded.
- Capture rule, per requester i at each edge:
  - `pending[i]` next = `evt_in[i] | (pending[i] & ~clr[i])`.
  - `clr[i]` = handshake on `out_id`==i.
- Drop rule: `evt_in[i]` & `pending[i]` & ~`clr[i]` is a drop.
  - An event arriving in the same cycle its pending bit is consumed re-arms the bit and is not a drop.
  - Drops in one cycle add their popcount to `drop_cnt`.
  - `drop_cnt` saturates at 2^`CNT_W`−1 and never wraps.
- Round-robin pick:
  - Search `pending` starting at index `rr_ptr`, ascending, wrapping at `N_REQ`−1→0.
  - The first set bit wins.
- FSM states:
  - IDLE: `out_valid`=0. If `enable` & |`pending`, load `out_id`←pick(`pending`), go to OFFER.
  - OFFER: `out_valid`=1; `out_id` held stable until handshake.
    - On handshake: `rr_ptr`←(`out_id`+1) mod `N_REQ`.
    - Let R = `pending` & ~onehot(`out_id`). If `enable` & |R, load `out_id`←pick(R) using the new pointer and stay in OFFER; otherwise go to IDLE.
  - `enable` deasserted in OFFER: the current offer is held until handshake, then the FSM goes to IDLE.
- `out_valid` never drops without a handshake, except on `rst`.

## Timing
- Latency: `evt_in[i]` high at edge k sets `pending[i]` at k. With the FSM in IDLE and `enable` high, `out_valid` is high after edge k+1, so the first offer appears 2 edges after the pulse.
- Throughput: one event per cycle with `out_ready` held high and requests waiting.
- `evt_in` bits arriving in the handshake cycle are not visible to that cycle's next pick; they become visible from the following cycle.
- Reset mid-OFFER: `out_valid` is low after the reset edge. The in-flight event is discarded and not counted as a drop.
- All outputs are registered except `busy` (= |`pending` | `out_valid`).

## Structure
- Shared package/include file holds the FSM state encoding (IDLE=1'b0, OFFER=1'b1) and the `ID_W` derivation.
- One sub-module, `rr_pick`: a combinational round-robin selector.
  - Inputs: request vector, start pointer.
  - Outputs: `found`, `idx`.
  - Parameterized by `N_REQ`.
- Everything else (pending register, FSM, counter) lives in the top module.

## Test plan
- Single event: `evt_in`=4'b0100 for one cycle, `out_ready`=1 → `out_valid` for exactly one cycle, 2 edges later, with `out_id`=2; `drop_cnt`=0.
- Fairness: `evt_in`=4'b1111 for one cycle, `out_ready`=1 → `out_id` sequence 0,1,2,3 on consecutive cycles. A second burst 4'b1001 then yields 0,3.
- Backpressure and drop: requester 1 pulses 3 times while `out_ready`=0 → `out_id`=1 held stable, `drop_cnt`=2. Raising `out_ready` gives one handshake, then IDLE.
- Re-arm on consume: `evt_in[0]` pulses in the exact handshake cycle for `out_id`=0 → no drop, and a second offer with `out_id`=0 follows.
- `enable` low: pulses on 0 and 2 with `enable`=0 → no `out_valid`, `busy`=1. Setting `enable`=1 gives offers with `out_id` 0 then 2. Deasserting `enable` mid-offer completes only the current offer.
- Saturation and reset: `CNT_W`=2 with 5 drops → `drop_cnt`=3. Asserting `rst` during OFFER → the next cycle shows `out_valid`=0, `drop_cnt`=0, `busy`=0.
